// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Purpose : Shared types and constants for the multi-cycle ALU (alu_seq).
//           The control-field constants match the decoder ROM bit layout
//           {za, ia, zb, ib}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_AND = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ABS  = 3'd2,
    ITER = 3'd3,
    EXEC = 3'd4,
    FIX  = 3'd5,
    DONE = 3'd6
  } state_e;

  // Operand-conditioning field, as emitted by the decoder ROM
  localparam logic [3:0] CF_ZA = 4'b1000;
  localparam logic [3:0] CF_IA = 4'b0100;
  localparam logic [3:0] CF_ZB = 4'b0010;
  localparam logic [3:0] CF_IB = 4'b0001;

  function automatic logic has_flag(input logic [3:0] ctl, input logic [3:0] flag);
    return |(ctl & flag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// ============================================================================
// Module  : alu_seq_muldiv
// Purpose : Iterative shift-add multiplier / restoring divider with sign
//           handling. go_i (one cycle) loads magnitudes and signs, WIDTH
//           iteration cycles follow, fin_o flags the last one. Results are
//           combinational from the final registers and sampled by the parent.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_muldiv #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go_i,
  input  logic             is_div_i,
  input  logic             signed_i,
  input  logic             high_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             skip_o,
  output logic             fin_o,
  output logic [WIDTH-1:0] result_o,
  output logic             over_o,
  output logic             divzero_o
);

  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, mb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_res_q, neg_rem_q, dz_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0]   mul_sum, div_r;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH:0]   prod_top;
  logic [WIDTH-1:0] quo_s, rem_s;

  // Operand magnitudes, divide-by-zero detect and one iteration step
  always_comb begin
    a_neg   = signed_i & a_i[WIDTH-1];
    b_neg   = signed_i & b_i[WIDTH-1];
    ma      = a_neg ? ('0 - a_i) : a_i;
    mb      = b_neg ? ('0 - b_i) : b_i;
    skip_o  = is_div_i && (b_i == '0);
    fin_o   = (cnt_q == CNT_W'(1));
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    div_r   = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, mb_q});
    // True difference is below the divisor, so the low WIDTH bits are exact
    div_sub = div_r[WIDTH-1:0] - mb_q;
  end

  // Sign fixup and result selection from the final iteration state
  always_comb begin
    prod      = {hi_q, lo_q};
    prod_s    = neg_res_q ? ('0 - prod) : prod;
    prod_top  = prod_s[2*WIDTH-1:WIDTH-1];
    quo_s     = neg_res_q ? ('0 - lo_q) : lo_q;
    rem_s     = neg_rem_q ? ('0 - hi_q) : hi_q;
    divzero_o = is_div_i & dz_q;
    if (is_div_i) begin
      if (dz_q) begin
        result_o = high_i ? lo_q : '1;
        over_o   = 1'b0;
      end else begin
        result_o = high_i ? rem_s : quo_s;
        // Only MIN / -1 yields a positive quotient with the top bit set
        over_o   = signed_i & ~neg_res_q & lo_q[WIDTH-1];
      end
    end else begin
      result_o = high_i ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
      over_o   = signed_i & ~high_i & ~((&prod_top) | ~(|prod_top));
    end
  end

  // Load on go, then one shift-add or restoring-subtract step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      mb_q      <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (go_i) begin
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= skip_o;
      mb_q      <= mb;
      hi_q      <= '0;
      if (skip_o) begin
        lo_q  <= a_i;
        cnt_q <= '0;
      end else begin
        lo_q  <= ma;
        cnt_q <= ITERS;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (is_div_i) begin
        if (div_ge) begin
          hi_q <= div_sub;
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= div_r[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Purpose : Multi-cycle ALU (ADD/AND/MUL/DIV) with start/busy/done handshake
//           and oe-gated output for the register bus.
//           Optional macro ALU_SEQ_FAST_MUL_EN: single-cycle multiplier in
//           EXEC instead of the iterative one (DIV unchanged).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [1:0]       op,
  input  logic             za,
  input  logic             ia,
  input  logic             zb,
  input  logic             ib,
  input  logic             io,
  input  logic             high,
  input  logic             signed_mode,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             oe,
  output logic [WIDTH-1:0] aluout,
  output logic             carryout,
  output logic             overout,
  output logic             divzero
);

  state_e           state_q;
  op_e              op_q;
  logic [3:0]       ctl_q;
  logic             high_q, sgn_q, cin_q;
  logic [WIDTH-1:0] a_q, b_q, ap_q, bp_q, result_q;
  logic             carry_q, over_q, dz_q, busy_q, done_q;

  logic [WIDTH-1:0] a_prep, b_prep;
  logic [WIDTH:0]   add_sum;
  logic             add_ovf, use_exec;
  logic             md_skip, md_fin, md_over, md_divzero;
  logic [WIDTH-1:0] md_result;

  // Operand conditioning (zero then invert) and the single-cycle ops
  always_comb begin
    a_prep  = (has_flag(ctl_q, CF_ZA) ? '0 : a_q) ^ {WIDTH{has_flag(ctl_q, CF_IA)}};
    b_prep  = (has_flag(ctl_q, CF_ZB) ? '0 : b_q) ^ {WIDTH{has_flag(ctl_q, CF_IB)}};
    add_sum = {1'b0, ap_q} + {1'b0, bp_q} + {{WIDTH{1'b0}}, cin_q};
    add_ovf = (ap_q[WIDTH-1] == bp_q[WIDTH-1]) && (add_sum[WIDTH-1] != ap_q[WIDTH-1]);
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*WIDTH-1:0] fm_a, fm_b, fm_prod;
  logic [WIDTH:0]     fm_top;
  logic               fm_ovf;

  assign use_exec = (op_q != OP_DIV);

  // Full-width product; sign extension selects signed vs unsigned multiply
  always_comb begin
    fm_a    = {{WIDTH{sgn_q & ap_q[WIDTH-1]}}, ap_q};
    fm_b    = {{WIDTH{sgn_q & bp_q[WIDTH-1]}}, bp_q};
    fm_prod = fm_a * fm_b;
    fm_top  = fm_prod[2*WIDTH-1:WIDTH-1];
    fm_ovf  = sgn_q & ~high_q & ~((&fm_top) | ~(|fm_top));
  end
`else
  assign use_exec = (op_q == OP_ADD) || (op_q == OP_AND);
`endif

  alu_seq_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .go_i      (state_q == ABS),
    .is_div_i  (op_q == OP_DIV),
    .signed_i  (sgn_q),
    .high_i    (high_q),
    .a_i       (ap_q),
    .b_i       (bp_q),
    .skip_o    (md_skip),
    .fin_o     (md_fin),
    .result_o  (md_result),
    .over_o    (md_over),
    .divzero_o (md_divzero)
  );

  // Control FSM with registered handshake and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      ctl_q    <= '0;
      high_q   <= 1'b0;
      sgn_q    <= 1'b0;
      cin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ap_q     <= '0;
      bp_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      over_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= op_e'(op);
            ctl_q    <= {za, ia, zb, ib};
            high_q   <= high;
            sgn_q    <= signed_mode;
            cin_q    <= carry_in;
            a_q      <= a;
            b_q      <= b;
            result_q <= '0;
            carry_q  <= 1'b0;
            over_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= PREP;
          end
        end
        PREP: begin
          ap_q    <= a_prep;
          bp_q    <= b_prep;
          state_q <= use_exec ? EXEC : ABS;
        end
        ABS:  state_q <= md_skip ? FIX : ITER;
        ITER: if (md_fin) state_q <= FIX;
        EXEC: begin
          case (op_q)
            OP_ADD: begin
              result_q <= add_sum[WIDTH-1:0];
              carry_q  <= add_sum[WIDTH];
              over_q   <= add_ovf;
            end
            OP_AND: result_q <= ap_q & bp_q;
`ifdef ALU_SEQ_FAST_MUL_EN
            OP_MUL: begin
              result_q <= high_q ? fm_prod[2*WIDTH-1:WIDTH] : fm_prod[WIDTH-1:0];
              over_q   <= fm_ovf;
            end
`endif
            default: ;
          endcase
          state_q <= DONE;
        end
        FIX: begin
          result_q <= md_result;
          over_q   <= md_over;
          dz_q     <= md_divzero;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign carryout = carry_q;
  assign overout  = over_q;
  assign divzero  = dz_q;
  assign aluout   = oe ? (result_q ^ {WIDTH{io}}) : '0;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module  : tb_alu_seq
// Purpose : Self-checking bench for alu_seq (WIDTH=8): directed cases plus
//           randomized operations against an integer-arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, busy, done;
  logic [1:0]   op;
  logic         za, ia, zb, ib, io, high, signed_mode, carry_in, oe;
  logic [W-1:0] a, b, aluout;
  logic         carryout, overout, divzero;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [1:0] op;
    logic       za, ia, zb, ib, io, high, sgn, cin, oe;
    logic [7:0] a, b;
  } req_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .op(op), .za(za), .ia(ia), .zb(zb), .ib(ib), .io(io), .high(high),
    .signed_mode(signed_mode), .carry_in(carry_in), .a(a), .b(b), .oe(oe),
    .aluout(aluout), .carryout(carryout), .overout(overout), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the conditioned operands
  function automatic void model(input req_t r, output int res, output int cout,
                                output int ovf, output int dz, output int lat);
    int     a1, b1, sa, sb, s, q, rm;
    longint p;
    a1 = r.za ? 0 : int'(r.a);
    if (r.ia) a1 = 255 - a1;
    b1 = r.zb ? 0 : int'(r.b);
    if (r.ib) b1 = 255 - b1;
    sa = (a1 > 127) ? a1 - 256 : a1;
    sb = (b1 > 127) ? b1 - 256 : b1;
    cout = 0; ovf = 0; dz = 0; res = 0; lat = 3;
    case (r.op)
      2'd0: begin
        s    = a1 + b1 + int'(r.cin);
        res  = s % 256;
        cout = s / 256;
        s    = sa + sb + int'(r.cin);
        ovf  = (s > 127 || s < -128) ? 1 : 0;
      end
      2'd1: res = a1 & b1;
      2'd2: begin
        p   = r.sgn ? longint'(sa) * longint'(sb) : longint'(a1) * longint'(b1);
        res = r.high ? int'((p >>> 8) & 255) : int'(p & 255);
        ovf = (r.sgn && !r.high && (p > 127 || p < -128)) ? 1 : 0;
`ifdef ALU_SEQ_FAST_MUL_EN
        lat = 3;
`else
        lat = 12;
`endif
      end
      default: begin
        if (b1 == 0) begin
          res = r.high ? a1 : 255;
          dz  = 1;
          lat = 4;
        end else begin
          if (r.sgn) begin q = sa / sb; rm = sa % sb; end
          else       begin q = a1 / b1; rm = a1 % b1; end
          res = (r.high ? rm : q) & 255;
          ovf = (r.sgn && q > 127) ? 1 : 0;
          lat = 12;
        end
      end
    endcase
    if (!r.oe) res = 0;
    else if (r.io) res = res ^ 255;
  endfunction

  function automatic req_t mk(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                              input logic hi, input logic sg, input logic ci,
                              input logic iov, input logic oev);
    req_t r;
    r = '0;
    r.op = o; r.a = av; r.b = bv; r.high = hi; r.sgn = sg;
    r.cin = ci; r.io = iov; r.oe = oev;
    return r;
  endfunction

  task automatic drive(input req_t r);
    op = r.op; za = r.za; ia = r.ia; zb = r.zb; ib = r.ib; io = r.io;
    high = r.high; signed_mode = r.sgn; carry_in = r.cin; a = r.a; b = r.b; oe = r.oe;
  endtask

  // Issue one op; optional start pokes at cycles poke1/poke2 must be ignored
  task automatic run_op(input string nm, input req_t r, input int poke1, input int poke2);
    int res, cout, ovf, dz, lat, n;
    bit busy_ok, extra;
    model(r, res, cout, ovf, dz, lat);
    @(negedge clk);
    drive(r);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_ok = 1'b1;
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin n = c; break; end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (c == poke1 || c == poke2) begin
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    check({nm, " latency"}, n, lat);
    check({nm, " busy while running"}, busy_ok, 1);
    check({nm, " busy at done"}, busy, 0);
    check({nm, " aluout"}, aluout, res);
    check({nm, " carryout"}, carryout, cout);
    check({nm, " overout"}, overout, ovf);
    check({nm, " divzero"}, divzero, dz);
    @(posedge clk);
    #1 check({nm, " done width"}, done, 0);
    if (poke1 > 0 || poke2 > 0) begin
      extra = 1'b0;
      for (int c = 0; c < 15; c++) begin
        @(posedge clk);
        #1 if (done || busy) extra = 1'b1;
      end
      check({nm, " no second op"}, extra, 0);
    end
  endtask

  initial begin
    req_t r;
    rst_n = 1'b0; start = 1'b0;
    drive(mk(2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset aluout", aluout, 0);
    check("reset carryout", carryout, 0);
    check("reset overout", overout, 0);
    check("reset divzero", divzero, 0);
    io = 1'b1;
    #1 check("reset aluout io", aluout, 8'hFF);
    io = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    run_op("add carry",   mk(2'd0, 8'hC8, 8'h64, 0, 0, 0, 0, 1), 0, 0);
    run_op("add ovf",     mk(2'd0, 8'h7F, 8'h01, 0, 0, 0, 0, 1), 0, 0);
    run_op("mul lo",      mk(2'd2, 8'hFF, 8'hFF, 0, 0, 0, 0, 1), 0, 0);
    run_op("mul hi",      mk(2'd2, 8'hFF, 8'hFF, 1, 0, 0, 0, 1), 0, 0);
    run_op("sdiv quo",    mk(2'd3, 8'hF9, 8'h02, 0, 1, 0, 0, 1), 0, 0);
    run_op("sdiv rem",    mk(2'd3, 8'hF9, 8'h02, 1, 1, 0, 0, 1), 0, 0);
    run_op("sdiv min",    mk(2'd3, 8'h80, 8'hFF, 0, 1, 0, 0, 1), 0, 0);
    run_op("smul ovf",    mk(2'd2, 8'h40, 8'h03, 0, 1, 0, 0, 1), 0, 0);
    run_op("div zero",    mk(2'd3, 8'h55, 8'h00, 0, 0, 0, 0, 1), 0, 0);
    run_op("add clr dz",  mk(2'd0, 8'h01, 8'h02, 0, 0, 1, 0, 1), 0, 0);
    run_op("mul pokes",   mk(2'd2, 8'h13, 8'h0B, 0, 0, 0, 0, 1), 2, 11);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    drive(mk(2'd2, 8'h12, 8'h34, 0, 0, 0, 0, 1));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("mid-op busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst aluout", aluout, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("after rst",   mk(2'd2, 8'h12, 8'h34, 1, 0, 0, 0, 1), 0, 0);

    run_op("and io",      mk(2'd1, 8'hF0, 8'h3C, 0, 0, 0, 1, 1), 0, 0);
    oe = 1'b0;
    #1 check("oe low aluout", aluout, 0);
    oe = 1'b1;
    run_op("add oe0",     mk(2'd0, 8'h33, 8'h44, 0, 0, 0, 0, 0), 0, 0);

    for (int i = 0; i < 40; i++) begin
      r      = '0;
      r.op   = 2'($urandom_range(0, 3));
      r.a    = 8'($urandom);
      r.b    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r.za   = ($urandom_range(0, 7) == 0);
      r.ia   = ($urandom_range(0, 3) == 0);
      r.zb   = ($urandom_range(0, 7) == 0);
      r.ib   = ($urandom_range(0, 3) == 0);
      r.io   = 1'($urandom);
      r.high = 1'($urandom);
      r.sgn  = 1'($urandom);
      r.cin  = 1'($urandom);
      r.oe   = ($urandom_range(0, 5) != 0);
      run_op($sformatf("rand%0d op%0d", i, r.op), r, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle ALU; next generation of the 8-bit core ALU.
- Executes add/and/multiply/divide on WIDTH-bit operands.
- Uses a start/busy/done handshake. Multiply and divide are iterative (shift-add and restoring).
- Sits between the control decoder (which supplies already-decoded control bits) and the register bus (tri-state-style oe gating).

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse when result valid
- op  in  2  0=ADD 1=AND 2=MUL 3=DIV
- za, ia, zb, ib  in  1 each  zero/invert A, zero/invert B (applied in that order)
- io  in  1  invert output
- high  in  1  MUL: select upper product half; DIV: select remainder
- signed_mode  in  1  signed MUL/DIV
- carry_in  in  1  ADD carry input
- a, b  in  WIDTH  operands
- oe  in  1  output enable
- aluout  out  WIDTH  oe ? (result ^ {WIDTH{io}}) : 0; combinational
- carryout  out  1  ADD carry; 0 for other ops
- overout  out  1  signed overflow (see Behaviour)
- divzero  out  1  last DIV had b'==0

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, carryout=0, overout=0, divzero=0, counter=0.
  - aluout follows oe ? {WIDTH{io}} : 0.
- States:
  - IDLE: start=1 latches op/controls/a/b → PREP, busy=1. start=0 stays.
  - PREP: a'=(za?0:a)^{ia}, b'=(zb?0:b)^{ib}. ADD/AND → EXEC. MUL/DIV → ABS.
  - ABS: if signed_mode, take magnitudes and record the sign of the product/quotient and of the dividend. DIV with b'==0 skips to FIX. Otherwise counter=WIDTH → ITER.
  - ITER: one shift-add (MUL) or restoring subtract (DIV) step per cycle. counter decrements; at 1 → FIX.
  - EXEC: ADD gives result={a'+b'+carry_in}[WIDTH-1:0], carryout=bit WIDTH. AND gives result=a'&b'. → DONE.
  - FIX: apply signs. MUL: result=high ? P[2W-1:W] : P[W-1:0]. DIV: result=high ? remainder : quotient. → DONE.
  - DONE: done=1 for exactly this cycle; busy=0 on the next edge → IDLE.
- Latency, from the start-accepting edge to the edge that raises done:
  - ADD/AND: 3 cycles.
  - MUL/DIV: WIDTH+4 cycles.
  - DIV by zero: 4 cycles.
- start while busy is ignored; no queueing. start in the DONE cycle is also ignored.
- Result, carryout, overout and divzero hold until the next accepted start. They are cleared when that start is accepted.
- Signed DIV truncates toward zero; the remainder takes the dividend's sign.
- DIV by zero:
  - quotient={WIDTH{1}}, remainder=a', divzero=1.
  - No ITER cycles.
- overout:
  - ADD: sign rule on a', b', result.
  - MUL signed, high=0: 1 if the full product does not fit in WIDTH bits.
  - DIV signed: 1 for MIN/−1; quotient wraps to MIN.
  - Otherwise 0.
- Unsigned mode ignores sign handling entirely.

Optional Feature:
- Macro ALU_SEQ_FAST_MUL_EN.
- Defined: MUL uses a single-cycle combinational multiplier in EXEC (signed or unsigned per signed_mode); MUL latency is 3. DIV is unchanged.
- Undefined: iterative multiplier with WIDTH+4 latency. No `*` operator appears in the RTL.

Decomposition:
- Package alu_seq_pkg holds:
  - typedef enum op_e {OP_ADD, OP_AND, OP_MUL, OP_DIV};
  - typedef enum state_e {IDLE, PREP, ABS, ITER, EXEC, FIX, DONE};
  - 4-bit control-field constants shared with the decoder ROM.
- Sub-module alu_seq_muldiv holds the ABS/ITER/FIX datapath, counter and sign fixup. It has its own go/fin handshake to the parent FSM.

Test Plan (WIDTH=8):
- ADD a=0xC8, b=0x64, carry_in=0 → result 0x2C, carryout=1, overout=0; done exactly 3 cycles after start. Then a=0x7F, b=0x01 → 0x80, overout=1.
- MUL unsigned a=0xFF, b=0xFF: high=0 → 0x01; high=1 → 0xFE. done at cycle 12; busy high cycles 1–11.
- DIV signed a=0xF9 (−7), b=0x02: high=0 → 0xFD; high=1 → 0xFF. Then a=0x80, b=0xFF → 0x80, overout=1.
- DIV a=0x55, b=0x00 → quotient 0xFF, divzero=1, done at cycle 4. Next ADD clears divzero.
- Pulse start again at cycles 2 and 11 of a MUL → ignored, single done. Drop rst_n at cycle 5 of a MUL → busy=0, done=0, result=0 immediately. A new op after release completes normally.
- oe=0 → aluout=0 regardless of result. oe=1, io=1, AND a=0xF0, b=0x3C → aluout=0xCF.
